stage_data_buffer: RTL and testbench
====================================

// Module: stage_data_buffer
// PURPOSE
//  Datapath stage downstream of the 3-state phase controller (IN/BUFF/OUT). Consumes the controller's
//  registered 2-bit state output and moves words accordingly: accepts words in IN, holds them in BUFF,
//  drains them in OUT. In-order FIFO storage; ready/valid handshakes on both sides; error/drop telemetry.
// PARAMETERS
//  DATA_W  8  word width in bits
//  DEPTH   8  FIFO depth in words; power of 2, >=2
//  CNT_W   8  width of the saturating drop counter
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  reset       in   1           synchronous, active-high
//  state       in   2           phase from controller: 00 IN, 01 BUFF, 10 OUT, 11 illegal
//  in_valid    in   1           upstream word valid
//  in_data     in   DATA_W      upstream word
//  in_ready    out  1           stage accepts in_data this cycle
//  out_valid   out  1           out_data valid
//  out_data    out  DATA_W      head-of-FIFO word
//  out_ready   in   1           downstream accepts out_data
//  count       out  log2(DEPTH)+1  words stored, 0..DEPTH
//  full        out  1           count==DEPTH
//  empty       out  1           count==0
//  drop_cnt    out  CNT_W       saturating count of cycles with in_valid && !in_ready
//  state_err   out  1           sticky: state==11 seen since reset
// BEHAVIOUR
//  - Reset (sync, active-high): wr/rd pointers 0, count 0, drop_cnt 0, state_err 0; storage not cleared.
//    While reset is high: in_ready=0, out_valid=0; empty=1, full=0 from the cleared count.
//  - in_ready  = !reset && state==IN && !full (combinational). Write when in_valid && in_ready.
//  - out_valid = !reset && state==OUT && !empty (combinational). Read when out_valid && out_ready.
//  - out_data = mem[rd_ptr] (first-word fall-through); holds head value while out_valid && !out_ready.
//  - Latency: word written at edge N is visible on out_data from cycle N+1 if state==OUT and FIFO was empty.
//  - BUFF: no writes, no reads; contents, pointers, count unchanged regardless of in_valid/out_ready.
//  - State 11: treated as BUFF (hold) and sets state_err on the next edge; cleared only by reset.
//  - Writes and reads are mutually exclusive by state, so no simultaneous read/write in the same cycle.
//    count updates +1 on write, -1 on read, otherwise unchanged.
//  - Pointers are log2(DEPTH)+1 bits; wrap modulo 2*DEPTH. full when MSBs differ and low bits are equal;
//    empty when the pointers are equal.
//  - Full in IN: in_ready=0, no write. Empty in OUT: out_valid=0, out_ready ignored.
//  - drop_cnt increments every cycle in_valid && !in_ready (wrong phase, full, or reset low only);
//    it saturates at all-ones and never wraps. It does not count during reset.
//  - Phase change mid-transfer: the handshake is evaluated on the current state only. A word offered in
//    the cycle the state leaves IN is dropped (counted). No pending-transaction memory.
//  - Reset mid-operation: all stored words are discarded (pointers cleared). Outputs are valid the cycle
//    after reset deasserts.
//  - Entering OUT->BUFF->OUT keeps the remaining words; the drain resumes at the same head.
// STRUCTURE
//  - Shared package stage_pkg: state encodings ST_IN=2'b00, ST_BUFF=2'b01, ST_OUT=2'b10.
//    The phase controller uses the same constants.
//  - Sub-module stage_fifo (DATA_W, DEPTH): mem array, pointers, count/full/empty, wr_en/rd_en inputs.
//    The top level holds the phase decode, handshake gating, drop_cnt and state_err.
// TESTING
//  1 Reset, then state=IN, send 3 words 0x11,0x22,0x33 -> count=3, drop_cnt=0, out_valid=0.
//  2 Same fill, then state=BUFF for 5 cycles with in_valid=1, out_ready=1 -> count=3, drop_cnt=5.
//  3 Then state=OUT with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, then empty=1, out_valid=0.
//  4 With DEPTH=8, in IN send 10 words -> full=1 after 8, in_ready=0, drop_cnt=2, OUT drains words 1..8 in order.
//  5 OUT with out_ready toggling 1,0,1; switch to BUFF after 1 read, then back to OUT -> next word is word 2,
//    with no loss or duplication.
//  6 Drive state=11 for 1 cycle -> state_err=1 and stays 1 while count is unchanged; reset with count=4 ->
//    count=0, empty=1, state_err=0; drive in_valid=1 for 300 wrong-phase cycles -> drop_cnt=255 (CNT_W=8).

Source files
------------

// File: rtl/stage_pkg.sv
// Purpose: phase encodings shared by the phase controller and its datapath stages.
// Latency: none (constants and a pure decode helper).
// Backpressure: not applicable.
package stage_pkg;

  localparam logic [1:0] ST_IN   = 2'b00;
  localparam logic [1:0] ST_BUFF = 2'b01;
  localparam logic [1:0] ST_OUT  = 2'b10;
  localparam logic [1:0] ST_ILL  = 2'b11;

  // The illegal encoding behaves like BUFF: nothing moves.
  function automatic logic is_hold(input logic [1:0] st);
    return (st == ST_BUFF) || (st == ST_ILL);
  endfunction

endpackage

// File: rtl/stage_fifo.sv
// Purpose: in-order word store with wrap-bit pointers and fall-through head.
// Latency: a word written at edge N appears on rd_data from cycle N+1 when the store was empty.
// Backpressure: wr_en ignored when full, rd_en ignored when empty; callers gate with full/empty.
module stage_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              do_wr, do_rd;

  // Full when the wrap bits differ over equal indices; empty when pointers match.
  always_comb begin
    full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    count   = wr_ptr_q - rd_ptr_q;
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
    do_wr   = wr_en && !full;
    do_rd   = rd_en && !empty;
  end

  // Next pointer values; reset discards every stored word by realigning the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  // Storage is deliberately not cleared by reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/stage_data_buffer.sv
// Purpose: phase-driven word buffer: accept in IN, hold in BUFF (and illegal), drain in OUT.
// Latency: first-word fall-through, write at edge N readable from cycle N+1 in OUT.
// Backpressure: in_ready low outside IN or when full; out_valid low outside OUT or when empty.
module stage_data_buffer
  import stage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             state,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   state_err
);

  logic             wr_en, rd_en, hold;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             state_err_q, state_err_d;

  stage_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Handshakes look only at the current phase; there is no pending-transfer memory.
  always_comb begin
    hold      = is_hold(state);
    in_ready  = !reset && !hold && (state == ST_IN)  && !full;
    out_valid = !reset && !hold && (state == ST_OUT) && !empty;
    wr_en     = in_valid && in_ready;
    rd_en     = out_valid && out_ready;
  end

  // Drop counter saturates; the sticky error latches on the illegal encoding until reset.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    state_err_d = state_err_q;
    if (reset) begin
      drop_cnt_d  = '0;
      state_err_d = 1'b0;
    end else begin
      if (in_valid && !in_ready && (drop_cnt_q != {CNT_W{1'b1}}))
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      if (state == ST_ILL)
        state_err_d = 1'b1;
    end
  end

  // Telemetry registers.
  always_ff @(posedge clk) begin
    drop_cnt_q  <= drop_cnt_d;
    state_err_q <= state_err_d;
  end

  assign drop_cnt  = drop_cnt_q;
  assign state_err = state_err_q;

endmodule

// File: tb/tb_stage_data_buffer.sv
module tb_stage_data_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        state = 2'b01;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [3:0]        count;
  logic              full, empty;
  logic [CNT_W-1:0]  drop_cnt;
  logic              state_err;

  int n_checks = 0;
  int n_fail   = 0;

  stage_data_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt),
    .state_err (state_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus telemetry integers.
  logic [DATA_W-1:0] mq[$];
  int                m_drop = 0;
  bit                m_err  = 1'b0;

  function automatic bit m_in_ready();
    return !reset && state == 2'b00 && mq.size() < DEPTH;
  endfunction

  function automatic bit m_out_valid();
    return !reset && state == 2'b10 && mq.size() > 0;
  endfunction

  always @(posedge clk) begin
    bit ir, ov;
    ir = m_in_ready();
    ov = m_out_valid();
    if (reset) begin
      mq.delete();
      m_drop = 0;
      m_err  = 1'b0;
    end else begin
      if (state == 2'b11) m_err = 1'b1;
      if (in_valid && ir) mq.push_back(in_data);
      if (ov && out_ready) void'(mq.pop_front());
      if (in_valid && !ir && m_drop < 255) m_drop++;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("in_ready",  int'(in_ready),  int'(m_in_ready()));
    chk("out_valid", int'(out_valid), int'(m_out_valid()));
    if (m_out_valid()) chk("out_data", int'(out_data), int'(mq[0]));
    chk("count",     int'(count),     mq.size());
    chk("full",      int'(full),      int'(mq.size() == DEPTH));
    chk("empty",     int'(empty),     int'(mq.size() == 0));
    chk("drop_cnt",  int'(drop_cnt),  m_drop);
    chk("state_err", int'(state_err), int'(m_err));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state = 2'b01;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    state = 2'b00; in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state while reset is held.
    cyc(1);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    do_reset();

    // 1: three words in IN.
    push(8'h11); push(8'h22); push(8'h33);
    state = 2'b01;
    #1;
    chk("t1_count", int'(count), 3);
    chk("t1_drop", int'(drop_cnt), 0);
    chk("t1_out_valid", int'(out_valid), 0);

    // 2: BUFF holds everything, offered words are dropped.
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h99;
    cyc(5);
    in_valid = 1'b0;
    #1;
    chk("t2_count", int'(count), 3);
    chk("t2_drop", int'(drop_cnt), 5);

    // 3: OUT drains in order on consecutive cycles.
    state = 2'b10; out_ready = 1'b1;
    #1; chk("t3_w0", int'(out_data), 8'h11);
    cyc(); chk("t3_w1", int'(out_data), 8'h22);
    cyc(); chk("t3_w2", int'(out_data), 8'h33);
    cyc();
    chk("t3_empty", int'(empty), 1);
    chk("t3_out_valid", int'(out_valid), 0);

    // 4: overfill by two words.
    do_reset();
    state = 2'b00; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t4_full", int'(full), 1);
    chk("t4_in_ready", int'(in_ready), 0);
    chk("t4_drop", int'(drop_cnt), 2);
    state = 2'b10; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1; chk("t4_drain", int'(out_data), i);
      cyc();
    end
    chk("t4_empty", int'(empty), 1);

    // 5: stall, detour through BUFF, resume at the same head.
    do_reset();
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    state = 2'b10; out_ready = 1'b1;
    #1; chk("t5_head0", int'(out_data), 8'hA0);
    cyc();
    out_ready = 1'b0;
    cyc();
    chk("t5_stall", int'(out_data), 8'hA1);
    state = 2'b01; out_ready = 1'b1;
    cyc(2);
    chk("t5_buff_count", int'(count), 3);
    state = 2'b10;
    #1; chk("t5_resume", int'(out_data), 8'hA1);
    cyc();
    chk("t5_next", int'(out_data), 8'hA2);
    out_ready = 1'b0;

    // 6: illegal phase, reset clearing, drop counter saturation.
    do_reset();
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    state = 2'b11;
    cyc();
    state = 2'b01;
    #1;
    chk("t6_err", int'(state_err), 1);
    chk("t6_count", int'(count), 4);
    cyc(3);
    chk("t6_err_sticky", int'(state_err), 1);
    chk("t6_count_hold", int'(count), 4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_err", int'(state_err), 0);
    state = 2'b01; in_valid = 1'b1;
    cyc(300);
    in_valid = 1'b0;
    #1;
    chk("t6_drop_sat", int'(drop_cnt), 255);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
